fcs_crc32_multi: RTL and testbench
==================================

# fcs_crc32_multi

Parametrised Ethernet FCS engine for the MAC datapath: computes IEEE 802.3 CRC-32 over frames presented DATA_BYTES bytes per cycle with a tail byte-mask, in either generate mode (TX: produce FCS) or check mode (RX: verify frame+FCS against the residue). Sits between the MAC framer/deframer and the PCS-side interface, accepts one beat per clock with no backpressure, and reports a registered result one cycle after end-of-frame.

## Interface
- DATA_BYTES, 8: bytes per beat (1..16).
- POLY, 32'h04C11DB7: generator polynomial (normal form).
- INIT, 32'hFFFFFFFF: register preset at start of frame.
- XOR_OUT, 32'hFFFFFFFF: final inversion mask.
- RESIDUE, 32'hDEBB20E3: reflected register value after a good frame+FCS.

- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- mode  in  1  0 = generate, 1 = check; sampled on the SOP beat, held for the frame.
- in_valid  in  1  beat qualifier.
- in_sop  in  1  first beat of frame.
- in_eop  in  1  last beat of frame.
- in_data  in  8*DATA_BYTES  byte 0 in [7:0] is first on the wire.
- in_keep  in  DATA_BYTES  byte enables; all ones except on EOP beat.
- out_valid  out  1  one-cycle pulse, result valid.
- out_crc  out  32  FCS (register XOR XOR_OUT); transmit byte 0 = out_crc[7:0].
- out_ok  out  1  check mode: register == RESIDUE; 0 in generate mode.
- busy  out  1  frame in progress.
- err_proto  out  1  one-cycle pulse on protocol violation.

## Operation
- Reflected CRC: each byte consumed LSB first; register shifts right with reflected POLY (32'hEDB88320 for default).
- FSM: IDLE, IN_FRAME.
  - IDLE + valid&sop: crc = step(INIT, beat); latch mode; to IN_FRAME, or stay IDLE and emit result if eop same beat.
  - IN_FRAME + valid&!sop: crc = step(crc, beat); on eop emit result, to IDLE.
  - IN_FRAME + valid&sop: err_proto pulse, current frame dropped (no out_valid), new frame restarts from INIT.
  - IDLE + valid&!sop: beat ignored, err_proto pulse.
- Keep on EOP must be contiguous from bit 0 and nonzero; otherwise err_proto pulse, frame dropped, to IDLE. Keep != all-ones on non-EOP beat: err_proto, frame dropped, to IDLE.
- Beat update: compute partial CRC after k = 1..DATA_BYTES bytes, select by popcount(in_keep).
- in_valid low: state and crc hold; gaps inside a frame are legal.
- Result: out_crc = crc_final ^ XOR_OUT; out_ok = mode_latched & (crc_final == RESIDUE).

## Timing
- Throughput: one beat per cycle, back-to-back frames (EOP then SOP next cycle, or EOP/SOP single-beat frames every cycle).
- Latency: out_valid/out_crc/out_ok registered, asserted cycle after EOP beat accepted; out_crc/out_ok hold until next out_valid.
- busy = 1 in IN_FRAME.
- Reset values: out_valid 0, out_crc 32'h0, out_ok 0, busy 0, err_proto 0, crc INIT, state IDLE.
- Reset mid-frame: frame abandoned, no out_valid, outputs at reset values next edge.

## Structure
- Package fcs_crc_pkg: default POLY/INIT/XOR_OUT/RESIDUE constants, reflect32 function, state enum (IDLE, IN_FRAME).
- Sub-module crc32_byte_step: combinational one-byte reflected update (crc_in, byte -> crc_out), chained DATA_BYTES times via generate.

## Test plan
- Generate, DATA_BYTES=8: beat "12345678" sop keep 8'hFF, beat "9" eop keep 8'h01 -> next cycle out_valid=1, out_crc=32'hCBF43926, out_ok=0.
- Check: same bytes then 26 39 F4 CB (keep 8'h1F on beat 2) -> out_ok=1; flip one data bit -> out_ok=0, out_valid still pulses.
- Single-beat frames sop&eop every cycle, alternating keep 8'h01 ("1") / 8'h03 ("12") -> out_valid every cycle, CRCs 32'h83DCEFB7 / 32'h4F5344CD.
- Gaps: "123456789" with in_valid low for 3 cycles between beats -> 32'hCBF43926.
- Protocol: sop mid-frame -> err_proto pulse, first frame no out_valid, second frame correct; keep 8'h05 on eop -> err_proto, no out_valid; data without sop -> err_proto, state IDLE.
- Reset asserted mid-frame -> busy 0, no out_valid; following "123456789" frame -> 32'hCBF43926.

Source files
------------

// File: rtl/fcs_crc_pkg.sv
// rtl/fcs_crc_pkg.sv - shared constants, helpers and state type for the Ethernet FCS engine
package fcs_crc_pkg;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOR_OUT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic {
    IDLE,
    IN_FRAME
  } fcs_state_t;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// rtl/crc32_byte_step.sv - combinational one-byte reflected CRC-32 update, LSB of the byte first
module crc32_byte_step #(
  parameter logic [31:0] POLY_REFL = 32'hEDB88320
) (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/fcs_crc32_multi.sv
// rtl/fcs_crc32_multi.sv - multi-byte-per-beat Ethernet FCS generate/check engine
module fcs_crc32_multi
  import fcs_crc_pkg::*;
#(
  parameter int          DATA_BYTES = 8,
  parameter logic [31:0] POLY       = CRC_POLY,
  parameter logic [31:0] INIT       = CRC_INIT,
  parameter logic [31:0] XOR_OUT    = CRC_XOR_OUT,
  parameter logic [31:0] RESIDUE    = CRC_RESIDUE
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    mode,
  input  logic                    in_valid,
  input  logic                    in_sop,
  input  logic                    in_eop,
  input  logic [8*DATA_BYTES-1:0] in_data,
  input  logic [DATA_BYTES-1:0]   in_keep,
  output logic                    out_valid,
  output logic [31:0]             out_crc,
  output logic                    out_ok,
  output logic                    busy,
  output logic                    err_proto
);

  localparam logic [31:0] POLY_REFL = reflect32(POLY);

  fcs_state_t state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic        mode_q, mode_d;
  logic        emit, err;

  logic [31:0] partial [DATA_BYTES+1];
  logic [31:0] beat_crc;
  logic [DATA_BYTES-1:0] keep_p1;
  logic        keep_all, keep_tail_ok, beat_ok, mode_eff;

  // A SOP beat always restarts from INIT, even when it aborts a frame in progress.
  assign partial[0] = in_sop ? INIT : crc_q;

  for (genvar g = 0; g < DATA_BYTES; g++) begin : g_step
    crc32_byte_step #(
      .POLY_REFL (POLY_REFL)
    ) u_step (
      .crc_in  (partial[g]),
      .data    (in_data[8*g +: 8]),
      .crc_out (partial[g+1])
    );
  end

  // Keep is only accepted as a contiguous run from bit 0, so the highest set bit
  // equals popcount and selects the matching partial result.
  always_comb begin
    beat_crc = partial[0];
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (in_keep[k]) beat_crc = partial[k+1];
    end
  end

  assign keep_p1      = in_keep + DATA_BYTES'(1);
  assign keep_all     = &in_keep;
  assign keep_tail_ok = (|in_keep) && ((in_keep & keep_p1) == '0);
  assign beat_ok      = in_eop ? keep_tail_ok : keep_all;
  assign mode_eff     = in_sop ? mode : mode_q;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    mode_d  = mode_q;
    emit    = 1'b0;
    err     = 1'b0;
    if (in_valid) begin
      if (!in_sop && state_q == IDLE) begin
        err = 1'b1;
      end else begin
        if (in_sop) begin
          mode_d = mode;
          if (state_q == IN_FRAME) err = 1'b1;
        end
        if (!beat_ok) begin
          err     = 1'b1;
          state_d = IDLE;
          crc_d   = INIT;
        end else if (in_eop) begin
          emit    = 1'b1;
          state_d = IDLE;
          crc_d   = INIT;
        end else begin
          state_d = IN_FRAME;
          crc_d   = beat_crc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      crc_q     <= INIT;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_crc   <= 32'h0;
      out_ok    <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      mode_q    <= mode_d;
      out_valid <= emit;
      err_proto <= err;
      if (emit) begin
        out_crc <= beat_crc ^ XOR_OUT;
        out_ok  <= mode_eff && (beat_crc == RESIDUE);
      end
    end
  end

  assign busy = (state_q == IN_FRAME);

endmodule

// File: tb/tb_fcs_crc32_multi.sv
// tb/tb_fcs_crc32_multi.sv - scoreboard bench for fcs_crc32_multi
module tb_fcs_crc32_multi;

  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          mode;
  logic          in_valid;
  logic          in_sop;
  logic          in_eop;
  logic [8*DB-1:0] in_data;
  logic [DB-1:0] in_keep;
  logic          out_valid;
  logic [31:0]   out_crc;
  logic          out_ok;
  logic          busy;
  logic          err_proto;

  int n_checks = 0;
  int n_pass   = 0;
  int err_seen = 0;
  int err_exp  = 0;

  logic [7:0]  fb[$];
  logic [31:0] exp_crc_q[$];
  logic        exp_ok_q[$];

  fcs_crc32_multi #(.DATA_BYTES(DB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .out_valid (out_valid),
    .out_crc   (out_crc),
    .out_ok    (out_ok),
    .busy      (busy),
    .err_proto (err_proto)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Bit-serial reference register (no final inversion) over fb.
  function automatic logic [31:0] model_reg();
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (fb[i]) begin
      c ^= {24'h0, fb[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic drive(input logic v, input logic s, input logic e, input logic md,
                       input logic [8*DB-1:0] d, input logic [DB-1:0] k);
    in_valid = v; in_sop = s; in_eop = e; mode = md; in_data = d; in_keep = k;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  function automatic logic [8*DB-1:0] pack8();
    logic [8*DB-1:0] d = '0;
    for (int j = 0; j < DB; j++) if (j < fb.size()) d[8*j +: 8] = fb[j];
    return d;
  endfunction

  task automatic load_digits(input int n);
    fb.delete();
    for (int i = 1; i <= n; i++) fb.push_back(8'(8'h30 + i));
  endtask

  task automatic send_frame(input logic md, input int gap, input logic known, input logic [31:0] known_crc);
    int n = fb.size();
    int nb = (n + DB - 1) / DB;
    logic [31:0] r = model_reg();
    logic [8*DB-1:0] d;
    logic [DB-1:0] k;
    for (int b = 0; b < nb; b++) begin
      d = '0; k = '0;
      for (int j = 0; j < DB; j++) begin
        if (b*DB + j < n) begin
          d[8*j +: 8] = fb[b*DB + j];
          k[j] = 1'b1;
        end
      end
      if (b == nb - 1) begin
        exp_crc_q.push_back(known ? known_crc : (r ^ 32'hFFFFFFFF));
        exp_ok_q.push_back(md && (r == 32'hDEBB20E3));
      end
      drive(1'b1, b == 0, b == nb - 1, md, d, k);
      if (b != nb - 1) idle(gap);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (err_proto) err_seen++;
      if (out_valid) begin
        if (exp_crc_q.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
        else begin
          check("out_crc", out_crc, exp_crc_q.pop_front());
          check("out_ok", {31'h0, out_ok}, {31'h0, exp_ok_q.pop_front()});
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    mode = 0; in_valid = 0; in_sop = 0; in_eop = 0; in_data = '0; in_keep = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_out_crc", out_crc, 32'h0);
    check("rst_out_ok", {31'h0, out_ok}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_err", {31'h0, err_proto}, 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Generate mode, known answer
    load_digits(9);
    send_frame(1'b0, 0, 1'b1, 32'hCBF43926);
    idle(3);

    // Check mode with FCS appended, then with a corrupted data bit
    load_digits(9);
    fb.push_back(8'h26); fb.push_back(8'h39); fb.push_back(8'hF4); fb.push_back(8'hCB);
    send_frame(1'b1, 0, 1'b0, 32'h0);
    fb[2] ^= 8'h10;
    send_frame(1'b1, 0, 1'b0, 32'h0);
    idle(3);

    // Single-beat frames every cycle, alternating lengths
    for (int i = 0; i < 6; i++) begin
      load_digits((i % 2 == 0) ? 1 : 2);
      send_frame(1'b0, 0, 1'b1, (i % 2 == 0) ? 32'h83DCEFB7 : 32'h4F5344CD);
    end
    idle(3);

    // Gaps inside a frame
    load_digits(9);
    send_frame(1'b0, 3, 1'b1, 32'hCBF43926);
    idle(3);

    // SOP in the middle of a frame: first frame dropped, second correct
    load_digits(8);
    drive(1'b1, 1'b1, 1'b0, 1'b0, pack8(), 8'hFF);
    check("busy_in_frame", {31'h0, busy}, 32'd1);
    err_exp++;
    load_digits(9);
    send_frame(1'b0, 0, 1'b1, 32'hCBF43926);
    idle(3);
    check("err_sop_mid", err_seen, err_exp);

    // Non-contiguous keep on EOP
    load_digits(8);
    drive(1'b1, 1'b1, 1'b0, 1'b0, pack8(), 8'hFF);
    drive(1'b1, 1'b0, 1'b1, 1'b0, pack8(), 8'h05);
    err_exp++;
    idle(3);
    check("err_bad_keep", err_seen, err_exp);
    check("busy_after_bad_keep", {31'h0, busy}, 32'd0);

    // Data without SOP while idle
    drive(1'b1, 1'b0, 1'b0, 1'b0, pack8(), 8'hFF);
    err_exp++;
    idle(3);
    check("err_no_sop", err_seen, err_exp);
    check("busy_no_sop", {31'h0, busy}, 32'd0);

    // Reset in the middle of a frame
    load_digits(8);
    drive(1'b1, 1'b1, 1'b0, 1'b0, pack8(), 8'hFF);
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'h0, busy}, 32'd0);
    check("rst_mid_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_mid_out_crc", out_crc, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);
    load_digits(9);
    send_frame(1'b0, 0, 1'b1, 32'hCBF43926);
    idle(5);

    check("scoreboard_drained", exp_crc_q.size(), 32'd0);
    check("err_total", err_seen, err_exp);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
